// File: rtl/legv8_bus_arbiter.sv
// Round-robin arbiter for the shared tri-state LEGv8 system bus.
// Registered one-hot grants, enforced idle turnaround between owners and a hold limit under contention.
module legv8_bus_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int TURNAROUND  = 1,
    parameter int MAX_HOLD    = 16,
    localparam int OWNER_W    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic [NUM_MASTERS-1:0] req_i,
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic [OWNER_W-1:0]     owner_id_o,
    output logic                   bus_busy_o,
    output logic                   preempt_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_TURN  = 2'd2;

    localparam logic [7:0]         HOLD_LAST = 8'(MAX_HOLD - 1);
    localparam logic [3:0]         TURN_INIT = 4'(TURNAROUND - 1);
    localparam logic [OWNER_W-1:0] LAST_IDX  = OWNER_W'(NUM_MASTERS - 1);

    logic [1:0]             state_q, state_d;
    logic [OWNER_W-1:0]     owner_q, owner_d;
    logic [OWNER_W-1:0]     ptr_q, ptr_d;
    logic [7:0]             hold_q, hold_d;
    logic [3:0]             turn_q, turn_d;
    logic                   preempt_q, preempt_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;

    logic [OWNER_W-1:0]     cand_idx [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] cand_hit;
    logic [OWNER_W-1:0]     pick_idx;
    logic [OWNER_W-1:0]     owner_next;
    logic                   any_req;
    logic                   owner_released;
    logic                   others_req;
    logic                   hold_expired;

    // Candidate gi is the master gi places after the priority pointer.
    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_rot
            logic [OWNER_W:0] sum;
            assign sum           = {1'b0, ptr_q} + (OWNER_W+1)'(gi);
            assign cand_idx[gi]  = (sum >= (OWNER_W+1)'(NUM_MASTERS))
                                   ? OWNER_W'(sum - (OWNER_W+1)'(NUM_MASTERS))
                                   : OWNER_W'(sum);
            assign cand_hit[gi]  = req_i[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        pick_idx = ptr_q;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                pick_idx = cand_idx[k];
            end
        end
    end

    // grant_q is onehot(owner) while in GRANT, so it doubles as the owner mask.
    assign any_req        = |req_i;
    assign owner_released = ~|(req_i & grant_q);
    assign others_req     = |(req_i & ~grant_q);
    assign hold_expired   = (hold_q == HOLD_LAST) && others_req && !owner_released;
    assign owner_next     = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        turn_d    = turn_q;
        preempt_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    owner_d = pick_idx;
                    hold_d  = '0;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (owner_released || hold_expired) begin
                    state_d   = S_TURN;
                    turn_d    = TURN_INIT;
                    ptr_d     = owner_next;
                    preempt_d = hold_expired;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            S_TURN: begin
                if (turn_q != '0) begin
                    turn_d = turn_q - 4'd1;
                end else if (any_req) begin
                    owner_d = pick_idx;
                    hold_d  = '0;
                    state_d = S_GRANT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_grant
            assign grant_d[gi] = (state_d == S_GRANT) && (owner_d == OWNER_W'(gi));
        end
    endgenerate

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            turn_q    <= '0;
            preempt_q <= 1'b0;
            grant_q   <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            turn_q    <= turn_d;
            preempt_q <= preempt_d;
            grant_q   <= grant_d;
        end
    end

    assign grant_o    = grant_q;
    assign owner_id_o = owner_q;
    assign bus_busy_o = (state_q != S_IDLE);
    assign preempt_o  = preempt_q;

endmodule

// File: tb/tb_legv8_bus_arbiter.sv
// Bench for legv8_bus_arbiter: ownership-level model checked every cycle plus directed literal checks.
module tb_legv8_bus_arbiter;

    localparam int N    = 4;
    localparam int TURN = 1;
    localparam int MAXH = 4;

    logic         clk = 1'b0;
    logic         reset_i;
    logic [N-1:0] req_i;
    logic [N-1:0] grant_o;
    logic [1:0]   owner_id_o;
    logic         bus_busy_o;
    logic         preempt_o;

    int vectors     = 0;
    int miscompares = 0;

    legv8_bus_arbiter #(
        .NUM_MASTERS(N),
        .TURNAROUND (TURN),
        .MAX_HOLD   (MAXH)
    ) dut (
        .clock_i   (clk),
        .reset_i   (reset_i),
        .req_i     (req_i),
        .grant_o   (grant_o),
        .owner_id_o(owner_id_o),
        .bus_busy_o(bus_busy_o),
        .preempt_o (preempt_o)
    );

    always #5 clk = ~clk;

    // Model in ownership terms: who holds the bus, for how many cycles, and how long the bus has been quiet.
    int m_owner = -1;
    int m_last  = 0;
    int m_ptr   = 0;
    int m_held  = 0;
    int m_gap   = -1;
    bit m_pre   = 1'b0;
    bit started = 1'b0;

    function automatic int model_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step();
        int p;
        bit rel;
        bit others;
        logic [N-1:0] mask;
        p = -1;
        if (reset_i) begin
            m_owner = -1; m_last = 0; m_ptr = 0; m_held = 0; m_gap = -1; m_pre = 1'b0;
        end else begin
            m_pre = 1'b0;
            if (m_owner >= 0) begin
                mask   = 4'b0001 << m_owner;
                rel    = (req_i & mask) == 0;
                others = (req_i & ~mask) != 0;
                if (rel || (m_held >= MAXH && others)) begin
                    m_pre   = !rel;
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                    m_gap   = 0;
                end else begin
                    m_held++;
                end
            end else if (m_gap >= 0) begin
                m_gap++;
                if (m_gap >= TURN) begin
                    p = model_pick(req_i, m_ptr);
                    if (p < 0) m_gap = -1;
                end
            end else begin
                p = model_pick(req_i, m_ptr);
            end
            if (p >= 0) begin
                m_owner = p; m_last = p; m_held = 1; m_gap = -1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input bit show);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else if (show) begin
            $display("check %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            started = 1'b1;
        end
    end

    initial begin
        logic [N-1:0] eg;
        forever begin
            @(negedge clk);
            if (started) begin
                eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
                chk("model_grant",    32'(grant_o),    32'(eg),    1'b0);
                chk("model_owner_id", 32'(owner_id_o), 32'(m_last), 1'b0);
                chk("model_bus_busy", 32'(bus_busy_o), 32'((m_owner >= 0) || (m_gap >= 0)), 1'b0);
                chk("model_preempt",  32'(preempt_o),  32'(m_pre), 1'b0);
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        req_i   = '0;
        cycle();
        reset_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1;
        req_i   = 4'b1111;
        cycle();
        cycle();
        chk("reset_grant", 32'(grant_o), 32'h0, 1'b1);
        chk("reset_busy",  32'(bus_busy_o), 32'h0, 1'b1);
        reset_i = 1'b0;
        cycle();
        chk("first_grant", 32'(grant_o), 32'b0001, 1'b1);
        req_i = '0;
        cycle();
        cycle();

        // Single requester, release after three cycles.
        req_i = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("solo_grant", 32'(grant_o), 32'b0100, 1'b1);
        end
        req_i = '0;
        cycle();
        chk("solo_drop",  32'(grant_o),    32'h0, 1'b1);
        chk("solo_owner", 32'(owner_id_o), 32'd2, 1'b1);
        chk("solo_turn_busy", 32'(bus_busy_o), 32'h1, 1'b1);
        cycle();
        chk("solo_idle_busy", 32'(bus_busy_o), 32'h0, 1'b1);

        // All four request; each drops two cycles after its grant.
        do_reset();
        req_i = 4'b1111;
        cycle();
        for (int m = 0; m < N; m++) begin
            chk("rr_grant_a", 32'(grant_o), 32'(4'b0001 << m), 1'b1);
            cycle();
            chk("rr_grant_b", 32'(grant_o), 32'(4'b0001 << m), 1'b1);
            req_i[m] = 1'b0;
            cycle();
            chk("rr_gap", 32'(grant_o), 32'h0, 1'b1);
            if (m < N - 1) cycle();
        end
        cycle();

        // Preemption after MAX_HOLD cycles under contention.
        do_reset();
        req_i = 4'b0001;
        cycle();
        req_i = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("hold_grant", 32'(grant_o), 32'b0001, 1'b1);
        end
        chk("hold_no_preempt", 32'(preempt_o), 32'h0, 1'b1);
        cycle();
        chk("preempt_pulse", 32'(preempt_o), 32'h1, 1'b1);
        chk("preempt_gap",   32'(grant_o),   32'h0, 1'b1);
        cycle();
        chk("preempt_next",  32'(grant_o),   32'b0100, 1'b1);
        chk("preempt_clear", 32'(preempt_o), 32'h0, 1'b1);
        req_i = '0;
        cycle();
        cycle();

        // Sole requester is never preempted.
        do_reset();
        req_i = 4'b1000;
        for (int i = 0; i < 20; i++) begin
            cycle();
            chk("sole_grant", 32'(grant_o), 32'b1000, 1'b0);
        end
        chk("sole_long_hold", 32'(grant_o), 32'b1000, 1'b1);
        req_i = '0;
        cycle();
        cycle();

        // Owner drops on the same edge its hold limit expires: plain release.
        do_reset();
        req_i = 4'b0011;
        for (int i = 0; i < 4; i++) cycle();
        chk("tie_grant", 32'(grant_o), 32'b0001, 1'b1);
        req_i = 4'b0010;
        cycle();
        chk("tie_no_preempt", 32'(preempt_o), 32'h0, 1'b1);
        cycle();
        chk("tie_next", 32'(grant_o), 32'b0010, 1'b1);
        req_i = '0;
        cycle();
        cycle();

        // Reset during GRANT drops the bus immediately and restores ptr=0.
        do_reset();
        req_i = 4'b0100;
        cycle();
        chk("mid_owner", 32'(owner_id_o), 32'd2, 1'b1);
        cycle();
        reset_i = 1'b1;
        cycle();
        chk("mid_reset_grant", 32'(grant_o), 32'h0, 1'b1);
        chk("mid_reset_busy",  32'(bus_busy_o), 32'h0, 1'b1);
        reset_i = 1'b0;
        req_i   = 4'b0101;
        cycle();
        chk("post_reset_grant", 32'(grant_o), 32'b0001, 1'b1);
        req_i = '0;
        cycle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/legv8_bus_arbiter.md
# legv8_bus_arbiter

Round-robin arbiter for the shared tri-state LEGv8 system bus (64-bit `data`, 32-bit `address`). Up to NUM_MASTERS bus masters contend for the bus: the CPU core, DMA engines and the debug port. The arbiter issues one-hot grants and enforces a minimum idle turnaround between owners so two masters never drive the tri-state nets on the same cycle. It also enforces a maximum hold time when other masters are waiting. It sits beside the CPU top level, and each master gates its tri-state enables with its grant bit.

## Interface
- NUM_MASTERS, 4: number of requesters; legal range 2..8.
- TURNAROUND, 1: minimum grant-free cycles between two ownerships; legal range 1..15.
- MAX_HOLD, 16: maximum consecutive grant cycles while another master is requesting; legal range 2..255.
- OWNER_W, derived: max(1, ceil(log2(NUM_MASTERS))).
- clock  in  1  single system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_MASTERS  level request per master, bit i = master i; held high for the whole transaction.
- grant  out  NUM_MASTERS  registered one-hot (or zero) grant; master i may drive the bus only while grant[i]=1.
- owner_id  out  OWNER_W  index of the current or last owner.
- bus_busy  out  1  high whenever the state is not IDLE.
- preempt  out  1  one-cycle pulse on the cycle grant drops because of a MAX_HOLD expiry.

## Operation
- States: IDLE, GRANT, TURN. `grant` = onehot(owner_id) in GRANT, else all zero.
- Priority pointer `ptr` names the highest-priority master. Pick = the first i with req[i]=1, scanning ptr, ptr+1, … modulo NUM_MASTERS.
- IDLE:
  - If any req bit is set: owner_id ← pick, hold_cnt ← 0, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT: the ownership ends on either of two conditions.
  - Release: req[owner_id]=0.
  - Preemption: hold_cnt = MAX_HOLD−1 and some other req bit is set.
  - On either: go to TURN, turn_cnt ← TURNAROUND−1, ptr ← (owner_id+1) mod NUM_MASTERS.
  - On preemption only: preempt ← 1 for one cycle.
  - Otherwise: hold_cnt increments, saturating at MAX_HOLD−1.
  - A sole requester is never preempted, however long it holds.
- TURN:
  - If turn_cnt ≠ 0: turn_cnt decrements.
  - If turn_cnt = 0 and any req bit is set: pick and go directly to GRANT.
  - If turn_cnt = 0 and no req bit is set: go to IDLE.
- A preempted master keeps req high. It is served again only after every other requester that was waiting, because the rotated ptr places it last.
- Requests that arrive during GRANT or TURN are not lost; they are evaluated at the next pick.
- req bits that rise and fall entirely within TURN are never granted. A request is only honoured if it is still asserted when the pick is made.
- Reset:
  - State → IDLE, grant = 0, owner_id = 0, ptr = 0, bus_busy = 0, preempt = 0.
  - hold_cnt and turn_cnt are cleared.
  - Reset asserted during GRANT removes the grant on the cycle after the reset edge, with no turnaround.

## Timing
- Grant latency from IDLE: req sampled high at edge k, so grant is visible in the cycle after edge k. That is 1 cycle.
- Release latency: req[owner] sampled low at edge k, so grant drops after edge k.
- Turnaround: grant stays zero for exactly TURNAROUND cycles, and the next grant appears on the following cycle if a request is pending.
- The maximum ownership under contention is MAX_HOLD cycles with grant high.
- No combinational path from req to grant; all outputs are registered.
- Simultaneous events:
  - Owner drops req on the same edge the hold limit expires: treated as a release, preempt stays 0.
  - Several requests in IDLE: exactly one bit is granted, per ptr.

## Test plan
All scenarios use NUM_MASTERS=4, TURNAROUND=1, MAX_HOLD=4.
- Reset with req=1111 → grant=0000, bus_busy=0 during reset. Cycle after reset release → grant=0001.
- req=0100 for 3 cycles then 0000 → grant=0100 for 3 cycles, then 0000, owner_id=2, bus_busy low after 1 TURN cycle.
- req=1111, each master dropping req 2 cycles after its grant → grant sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000.
- req[0] held high, req[2] raised at cycle 1 → grant=0001 for 4 cycles, preempt=1 on the drop cycle, 1 idle cycle, then grant=0100.
- Only req[3] held high for 20 cycles → grant=1000 continuously for 20 cycles, preempt never asserts.
- reset asserted mid-GRANT with owner 2 → grant=0000 on the next cycle. After release, req=0101 grants master 0 first (ptr=0).
